// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 800x600@60 raster constants and shared count width
package vga_pkg;

  localparam int VGA_CNT_W    = 11;

  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_H_FP     = 40;
  localparam int VGA_H_SYNC   = 128;
  localparam int VGA_H_BP     = 88;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 600;
  localparam int VGA_V_FP     = 1;
  localparam int VGA_V_SYNC   = 4;
  localparam int VGA_V_BP     = 23;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef logic [VGA_CNT_W-1:0] vga_cnt_t;

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - raster bundle driven by vga_timing and read by every draw stage
interface vga_if;
  import vga_pkg::*;

  vga_cnt_t hcount;
  vga_cnt_t vcount;
  logic     hsync;
  logic     vsync;
  logic     hblnk;
  logic     vblnk;

  modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);

endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping count with registered sync/blank
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BP     = VGA_H_BP,
  parameter bit POL    = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  output vga_cnt_t cnt,
  output logic     sync,
  output logic     blnk,
  output logic     wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  if (TOTAL > (1 << VGA_CNT_W) || TOTAL < 1) begin : g_total_check
    $error("vga_axis_counter: axis total %0d does not fit the count width", TOTAL);
  end

  // One extra bit so a boundary equal to 2048 still compares correctly
  localparam logic [VGA_CNT_W:0] L_ACTIVE     = (VGA_CNT_W+1)'(ACTIVE);
  localparam logic [VGA_CNT_W:0] L_SYNC_START = (VGA_CNT_W+1)'(ACTIVE + FP);
  localparam logic [VGA_CNT_W:0] L_SYNC_END   = (VGA_CNT_W+1)'(ACTIVE + FP + SYNC);
  localparam vga_cnt_t           L_LAST       = vga_cnt_t'(TOTAL - 1);

  vga_cnt_t               w_nxt;
  logic [VGA_CNT_W:0]     w_nxt_ext;
  logic                   w_last;

  assign w_last    = (cnt == L_LAST);
  assign wrap      = en && w_last;
  assign w_nxt_ext = {1'b0, w_nxt};

  always_comb begin
    w_nxt = cnt;
    if (en) begin
      w_nxt = w_last ? '0 : cnt + vga_cnt_t'(1);
    end
  end

  // Sync and blank follow the next count so they line up with cnt in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sync <= ~POL;
      blnk <= 1'b0;
    end else begin
      cnt  <= w_nxt;
      blnk <= (w_nxt_ext >= L_ACTIVE);
      sync <= ((w_nxt_ext >= L_SYNC_START) && (w_nxt_ext < L_SYNC_END)) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - free-running VGA raster generator; VGA_TIMING_FRAME_CNT_EN adds frame_tick/frame_cnt
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.out          vout
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic        frame_tick,
  output logic [15:0] frame_cnt
`endif
);

  vga_cnt_t w_hcnt;
  vga_cnt_t w_vcnt;
  logic     w_hsync;
  logic     w_vsync;
  logic     w_hblnk;
  logic     w_vblnk;
  logic     w_h_wrap;
  logic     w_v_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (SYNC_POL)
  ) u_h (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .cnt  (w_hcnt),
    .sync (w_hsync),
    .blnk (w_hblnk),
    .wrap (w_h_wrap)
  );

  // Vertical axis steps only on the cycle the line wraps
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (SYNC_POL)
  ) u_v (
    .clk  (clk),
    .rst  (rst),
    .en   (w_h_wrap),
    .cnt  (w_vcnt),
    .sync (w_vsync),
    .blnk (w_vblnk),
    .wrap (w_v_wrap)
  );

  assign vout.hcount = w_hcnt;
  assign vout.vcount = w_vcnt;
  assign vout.hsync  = w_hsync;
  assign vout.vsync  = w_vsync;
  assign vout.hblnk  = w_hblnk;
  assign vout.vblnk  = w_vblnk;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic        r_frame_tick;
  logic [15:0] r_frame_cnt;
  logic        w_frame_end;

  assign w_frame_end = w_h_wrap & w_v_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_tick <= 1'b0;
      r_frame_cnt  <= 16'd0;
    end else begin
      r_frame_tick <= w_frame_end;
      if (w_frame_end) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign frame_tick = r_frame_tick;
  assign frame_cnt  = r_frame_cnt;
`else
  logic w_unused_v_wrap;
  assign w_unused_v_wrap = w_v_wrap;
`endif

endmodule
